// File: rtl/fpalu_issue_pkg.sv
// ---------------------------------------------------------------------------
// fpalu_issue_pkg
//   Shared definitions for the FPALU issue sequencer:
//   - FOP* opcode constants (the same encoding the FPALU decodes)
//   - data/opcode/flag widths
//   - sequencer state encoding and the packed flag record
// ---------------------------------------------------------------------------
package fpalu_issue_pkg;

  localparam int OPW = 5;   // opcode width
  localparam int DW  = 32;  // operand / result width
  localparam int FLW = 4;   // {nan, zero, overflow, underflow}

  // FPALU opcodes. Anything not listed is undefined and runs on the
  // zero-latency path, where the FPALU returns all-zero outputs.
  localparam logic [OPW-1:0] FOPADD   = 5'd0;
  localparam logic [OPW-1:0] FOPSUB   = 5'd1;
  localparam logic [OPW-1:0] FOPMUL   = 5'd2;
  localparam logic [OPW-1:0] FOPDIV   = 5'd3;
  localparam logic [OPW-1:0] FOPSQRT  = 5'd4;
  localparam logic [OPW-1:0] FOPABS   = 5'd5;
  localparam logic [OPW-1:0] FOPNEG   = 5'd6;
  localparam logic [OPW-1:0] FOPCEQ   = 5'd7;
  localparam logic [OPW-1:0] FOPCLT   = 5'd8;
  localparam logic [OPW-1:0] FOPCLE   = 5'd9;
  localparam logic [OPW-1:0] FOPCVTSW = 5'd10;
  localparam logic [OPW-1:0] FOPCVTWS = 5'd11;
  localparam logic [OPW-1:0] FOPSGNJ  = 5'd12;
  localparam logic [OPW-1:0] FOPSGNJN = 5'd13;
  localparam logic [OPW-1:0] FOPSGNJX = 5'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic nan;
    logic zero;
    logic overflow;
    logic underflow;
  } flags_t;

endpackage

// File: rtl/fpalu_issue_lat_lut.sv
// ---------------------------------------------------------------------------
// fpalu_lat_lut
//   Purely combinational opcode -> latency map. The value returned is the
//   number of extra WAIT cycles the sequencer spends before sampling the
//   FPALU outputs, i.e. the pipeline latency of the selected core.
// Ports
//   control_i  in   OPW   FOP* opcode being accepted
//   lat_o      out  CNTW  latency of that opcode in clocks
// ---------------------------------------------------------------------------
module fpalu_lat_lut
  import fpalu_issue_pkg::*;
#(
  parameter int CNTW     = 5,
  parameter int LAT_ADD  = 7,
  parameter int LAT_MUL  = 5,
  parameter int LAT_DIV  = 6,
  parameter int LAT_SQRT = 16,
  parameter int LAT_CMP  = 1,
  parameter int LAT_CVT  = 6,
  parameter int LAT_COMB = 0
) (
  input  logic [OPW-1:0]  control_i,
  output logic [CNTW-1:0] lat_o
);

  always_comb begin
    // Sign manipulation ops and undefined opcodes share the combinational path.
    lat_o = CNTW'(LAT_COMB);
    case (control_i)
      FOPADD, FOPSUB:            lat_o = CNTW'(LAT_ADD);
      FOPMUL:                    lat_o = CNTW'(LAT_MUL);
      FOPDIV:                    lat_o = CNTW'(LAT_DIV);
      FOPSQRT:                   lat_o = CNTW'(LAT_SQRT);
      FOPCEQ, FOPCLT, FOPCLE:    lat_o = CNTW'(LAT_CMP);
      FOPCVTSW, FOPCVTWS:        lat_o = CNTW'(LAT_CVT);
      default:                   lat_o = CNTW'(LAT_COMB);
    endcase
  end

endmodule

// File: rtl/fpalu_issue.sv
// ---------------------------------------------------------------------------
// fpalu_issue
//   Initiator-side sequencer for the pipelined FPALU. On an accepted request
//   it registers opcode/operands onto the FPALU inputs, holds them for the
//   opcode's fixed latency, then captures result, flags and compare bit.
//   A new request may be accepted in the DONE cycle, so ops issue back to
//   back with no idle cycle in between.
// Ports
//   iclock        in   1   clock
//   ireset        in   1   asynchronous active-high reset
//   istart        in   1   request, honoured only in IDLE or DONE
//   icontrol      in   5   FOP* opcode
//   idataa/b      in   32  operands
//   oalu_control  out  5   opcode to FPALU (held from accept to next accept)
//   oalu_dataa/b  out  32  operands to FPALU (held likewise)
//   ialu_result   in   32  FPALU result
//   ialu_flags    in   4   FPALU {nan, zero, overflow, underflow}
//   ialu_comp     in   1   FPALU compare result
//   obusy         out  1   high while waiting on the FPALU (stall request)
//   odone         out  1   one-cycle pulse, captured outputs are valid
//   oresult       out  32  captured result (held until next capture)
//   oflags        out  4   captured flags
//   ocompresult   out  1   captured compare bit
// ---------------------------------------------------------------------------
module fpalu_issue
  import fpalu_issue_pkg::*;
#(
  parameter int CNTW     = 5,
  parameter int LAT_ADD  = 7,
  parameter int LAT_MUL  = 5,
  parameter int LAT_DIV  = 6,
  parameter int LAT_SQRT = 16,
  parameter int LAT_CMP  = 1,
  parameter int LAT_CVT  = 6,
  parameter int LAT_COMB = 0
) (
  input  logic           iclock,
  input  logic           ireset,
  input  logic           istart,
  input  logic [OPW-1:0] icontrol,
  input  logic [DW-1:0]  idataa,
  input  logic [DW-1:0]  idatab,
  output logic [OPW-1:0] oalu_control,
  output logic [DW-1:0]  oalu_dataa,
  output logic [DW-1:0]  oalu_datab,
  input  logic [DW-1:0]  ialu_result,
  input  logic [FLW-1:0] ialu_flags,
  input  logic           ialu_comp,
  output logic           obusy,
  output logic           odone,
  output logic [DW-1:0]  oresult,
  output logic [FLW-1:0] oflags,
  output logic           ocompresult
);

  state_e          state_q, state_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] lat_w;
  logic            accept;
  logic            capture;

  logic [OPW-1:0]  ctrl_q;
  logic [DW-1:0]   dataa_q;
  logic [DW-1:0]   datab_q;
  logic [DW-1:0]   result_q;
  flags_t          flags_q;
  logic            comp_q;

  // Latency is looked up from the incoming opcode so it can be loaded on
  // the same edge the opcode is latched.
  fpalu_lat_lut #(
    .CNTW     (CNTW),
    .LAT_ADD  (LAT_ADD),
    .LAT_MUL  (LAT_MUL),
    .LAT_DIV  (LAT_DIV),
    .LAT_SQRT (LAT_SQRT),
    .LAT_CMP  (LAT_CMP),
    .LAT_CVT  (LAT_CVT),
    .LAT_COMB (LAT_COMB)
  ) u_lat_lut (
    .control_i (icontrol),
    .lat_o     (lat_w)
  );

  // Next-state logic. In WAIT the counter runs down to zero; the FPALU
  // outputs are sampled on the edge that finds the counter already at zero,
  // which places capture LAT+1 edges after the accept edge.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (istart) accept = 1'b1;
      end
      ST_WAIT: begin
        // istart is deliberately not looked at here: requests during an op
        // are dropped, not queued.
        if (count_q != '0) begin
          count_d = count_q - CNTW'(1);
        end else begin
          capture = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (istart) accept  = 1'b1;
        else        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (accept) begin
      state_d = ST_WAIT;
      count_d = lat_w;
    end
  end

  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // FPALU drive registers: loaded only on accept, so they stay constant for
  // the whole op and beyond until the next accepted request.
  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      ctrl_q  <= '0;
      dataa_q <= '0;
      datab_q <= '0;
    end else if (accept) begin
      ctrl_q  <= icontrol;
      dataa_q <= idataa;
      datab_q <= idatab;
    end
  end

  // Result capture registers: loaded only at the end of an op and held
  // through DONE and IDLE.
  always_ff @(posedge iclock or posedge ireset) begin
    if (ireset) begin
      result_q <= '0;
      flags_q  <= '0;
      comp_q   <= 1'b0;
    end else if (capture) begin
      result_q <= ialu_result;
      flags_q  <= flags_t'(ialu_flags);
      comp_q   <= ialu_comp;
    end
  end

  // Handshake outputs decode registered state only, so they are glitch-free
  // and independent of istart.
  assign obusy        = (state_q == ST_WAIT);
  assign odone        = (state_q == ST_DONE);

  assign oalu_control = ctrl_q;
  assign oalu_dataa   = dataa_q;
  assign oalu_datab   = datab_q;
  assign oresult      = result_q;
  assign oflags       = flags_q;
  assign ocompresult  = comp_q;

endmodule

// File: tb/tb_fpalu_issue.sv
`timescale 1ns/1ps
module tb_fpalu_issue;
  import fpalu_issue_pkg::*;

  localparam int CNTW     = 5;
  localparam int LAT_ADD  = 7;
  localparam int LAT_MUL  = 5;
  localparam int LAT_DIV  = 6;
  localparam int LAT_SQRT = 16;
  localparam int LAT_CMP  = 1;
  localparam int LAT_CVT  = 6;
  localparam int LAT_COMB = 0;

  logic        iclock = 1'b0;
  logic        ireset;
  logic        istart;
  logic [4:0]  icontrol;
  logic [31:0] idataa, idatab;
  logic [4:0]  oalu_control;
  logic [31:0] oalu_dataa, oalu_datab;
  logic [31:0] ialu_result;
  logic [3:0]  ialu_flags;
  logic        ialu_comp;
  logic        obusy, odone;
  logic [31:0] oresult;
  logic [3:0]  oflags;
  logic        ocompresult;

  int checks = 0;
  int errors = 0;

  always #5 iclock = ~iclock;

  fpalu_issue #(
    .CNTW(CNTW), .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV),
    .LAT_SQRT(LAT_SQRT), .LAT_CMP(LAT_CMP), .LAT_CVT(LAT_CVT), .LAT_COMB(LAT_COMB)
  ) dut (
    .iclock(iclock), .ireset(ireset), .istart(istart), .icontrol(icontrol),
    .idataa(idataa), .idatab(idatab),
    .oalu_control(oalu_control), .oalu_dataa(oalu_dataa), .oalu_datab(oalu_datab),
    .ialu_result(ialu_result), .ialu_flags(ialu_flags), .ialu_comp(ialu_comp),
    .obusy(obusy), .odone(odone), .oresult(oresult), .oflags(oflags),
    .ocompresult(ocompresult)
  );

  // ---------------- behavioural FPALU ----------------
  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flags;
    logic        comp;
  } alu_out_t;

  function automatic int lat_of(input logic [4:0] op);
    case (op)
      FOPADD, FOPSUB:         return LAT_ADD;
      FOPMUL:                 return LAT_MUL;
      FOPDIV:                 return LAT_DIV;
      FOPSQRT:                return LAT_SQRT;
      FOPCEQ, FOPCLT, FOPCLE: return LAT_CMP;
      FOPCVTSW, FOPCVTWS:     return LAT_CVT;
      default:                return LAT_COMB;
    endcase
  endfunction

  function automatic real f2r(input logic [31:0] b);
    int  e;
    real v;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    if (e > 127) for (int i = 0; i < e - 127; i++) v = v * 2.0;
    else         for (int i = 0; i < 127 - e; i++) v = v / 2.0;
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic        s;
    real         v;
    int          e;
    logic [22:0] m;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    v = s ? -x : x;
    e = 127;
    while (v >= 2.0 && e < 255) begin v = v / 2.0; e++; end
    while (v < 1.0 && e > 0)    begin v = v * 2.0; e--; end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    m = 23'($rtoi((v - 1.0) * 8388608.0));
    return {s, 8'(e), m};
  endfunction

  function automatic alu_out_t alu_eval(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    alu_out_t r;
    real      ra, rb;
    bit       arith;
    r = '0;
    ra = f2r(a);
    rb = f2r(b);
    arith = 1'b1;
    case (op)
      FOPADD:   r.res = r2f(ra + rb);
      FOPSUB:   r.res = r2f(ra - rb);
      FOPMUL:   r.res = r2f(ra * rb);
      FOPDIV:   r.res = (rb == 0.0) ? {a[31] ^ b[31], 8'hFF, 23'h0} : r2f(ra / rb);
      FOPSQRT:  r.res = (ra < 0.0) ? 32'h7FC00000 : r2f($sqrt(ra));
      FOPCVTSW: r.res = r2f(real'($signed(a)));
      FOPCVTWS: r.res = 32'($rtoi(ra));
      FOPABS:   r.res = {1'b0, a[30:0]};
      FOPNEG:   r.res = {~a[31], a[30:0]};
      FOPSGNJ:  r.res = {b[31], a[30:0]};
      FOPSGNJN: r.res = {~b[31], a[30:0]};
      FOPSGNJX: r.res = {a[31] ^ b[31], a[30:0]};
      FOPCEQ:   begin r.comp = (ra == rb); arith = 1'b0; end
      FOPCLT:   begin r.comp = (ra <  rb); arith = 1'b0; end
      FOPCLE:   begin r.comp = (ra <= rb); arith = 1'b0; end
      default:  arith = 1'b0;
    endcase
    if (arith) begin
      r.flags[3] = (r.res[30:23] == 8'hFF) && (r.res[22:0] != 0);
      r.flags[2] = (r.res[30:0] == 0);
      r.flags[1] = (r.res[30:23] == 8'hFF) && (r.res[22:0] == 0);
      r.flags[0] = 1'b0;
    end
    return r;
  endfunction

  // Pipeline behaviour: outputs become f(inputs) once the inputs have been
  // stable for LAT edges; before that the previous outputs are held.
  logic [4:0]  snap_op = '1;
  logic [31:0] snap_a = '1, snap_b = '1;
  int          age = 0;
  logic [31:0] held_res = '0;
  logic [3:0]  held_flags = '0;
  logic        held_comp = 1'b0;
  alu_out_t    model_now;
  logic        model_valid;

  always @(posedge iclock) begin
    if ({oalu_control, oalu_dataa, oalu_datab} == {snap_op, snap_a, snap_b}) begin
      if (age < 1000) age <= age + 1;
    end else begin
      snap_op <= oalu_control;
      snap_a  <= oalu_dataa;
      snap_b  <= oalu_datab;
      age     <= 1;
    end
    held_res   <= ialu_result;
    held_flags <= ialu_flags;
    held_comp  <= ialu_comp;
  end

  always @* begin
    model_now   = alu_eval(oalu_control, oalu_dataa, oalu_datab);
    model_valid = (lat_of(oalu_control) == 0) ||
                  (({oalu_control, oalu_dataa, oalu_datab} == {snap_op, snap_a, snap_b}) &&
                   (age >= lat_of(oalu_control)));
    if (model_valid) begin
      ialu_result = model_now.res;
      ialu_flags  = model_now.flags;
      ialu_comp   = model_now.comp;
    end else begin
      ialu_result = held_res;
      ialu_flags  = held_flags;
      ialu_comp   = held_comp;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclock);
    #1;
  endtask

  // Issue one op and follow it to odone. Returns in the DONE cycle.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc, input logic [31:0] exp_res,
                        input logic [3:0] exp_flags, input logic exp_comp, input bit spur);
    int n, busy, unstable;
    bit seen;
    istart = 1'b1; icontrol = op; idataa = a; idatab = b;
    n = 0; busy = 0; unstable = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (n == 1) begin
        istart = 1'b0;
        if (spur) begin
          istart = 1'b1; icontrol = FOPADD; idataa = $urandom; idatab = $urandom;
        end
      end else if (n == 2) begin
        istart = 1'b0;
      end
      if (obusy) busy++;
      if (oalu_control !== op || oalu_dataa !== a || oalu_datab !== b) unstable++;
      if (odone) seen = 1'b1;
    end
    istart = 1'b0;
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(n), 32'(exp_cyc));
    chk({tag, " busy_cycles"}, 32'(busy), 32'(exp_cyc - 1));
    chk({tag, " alu_inputs_held"}, 32'(unstable), 32'd0);
    chk({tag, " result"}, oresult, exp_res);
    chk({tag, " flags"}, 32'(oflags), 32'(exp_flags));
    chk({tag, " comp"}, 32'(ocompresult), 32'(exp_comp));
    $display("txn %s op=%0d a=%h b=%h cycles=%0d result=%h flags=%b comp=%0d",
             tag, op, a, b, n, oresult, oflags, ocompresult);
  endtask

  task automatic idle_gap(input string tag, input int cyc, input logic [31:0] held);
    for (int k = 0; k < cyc; k++) begin
      tick();
      chk({tag, " idle_odone"}, 32'(odone), 32'd0);
      chk({tag, " idle_obusy"}, 32'(obusy), 32'd0);
      chk({tag, " idle_result_hold"}, oresult, held);
    end
  endtask

  function automatic logic [31:0] rand_norm();
    logic [7:0] e;
    e = 8'($urandom_range(110, 144));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b;
    int          cyc;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        comp;
    bit          b2b;
    bit          spur;
  } vec_t;

  vec_t vt[11];

  initial begin
    logic [31:0] prev_res;
    int          nz;
    alu_out_t    e;
    logic [4:0]  op;
    logic [31:0] a, b;

    vt[0]  = '{FOPADD,   32'h3F800000, 32'h40000000, 9,  32'h40400000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{FOPDIV,   32'h3F800000, 32'h00000000, 8,  32'h7F800000, 4'b0010, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{FOPCLT,   32'h3F800000, 32'h40000000, 3,  32'h00000000, 4'b0000, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{FOPNEG,   32'h3F800000, 32'h00000000, 2,  32'hBF800000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{FOPMUL,   32'h3F800000, 32'h40000000, 7,  32'h40000000, 4'b0000, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{5'd31,    32'h12345678, 32'h9ABCDEF0, 2,  32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{FOPSUB,   32'h40400000, 32'h3F800000, 9,  32'h40000000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{FOPCEQ,   32'h3F800000, 32'h3F800000, 3,  32'h00000000, 4'b0000, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{FOPABS,   32'hBF800000, 32'h00000000, 2,  32'h3F800000, 4'b0000, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{FOPSQRT,  32'h40800000, 32'h00000000, 18, 32'h40000000, 4'b0000, 1'b0, 1'b0, 1'b1};
    vt[10] = '{FOPCVTSW, 32'h00000005, 32'h00000000, 8,  32'h40A00000, 4'b0000, 1'b0, 1'b0, 1'b0};

    ireset = 1'b0; istart = 1'b0; icontrol = '0; idataa = '0; idatab = '0;
    #2 ireset = 1'b1;
    tick(); tick();
    chk("reset obusy", 32'(obusy), 32'd0);
    chk("reset odone", 32'(odone), 32'd0);
    chk("reset oresult", oresult, 32'd0);
    chk("reset oflags", 32'(oflags), 32'd0);
    chk("reset ocomp", 32'(ocompresult), 32'd0);
    chk("reset oalu_control", 32'(oalu_control), 32'd0);
    ireset = 1'b0;
    tick(); tick();
    chk("post-reset idle obusy", 32'(obusy), 32'd0);

    prev_res = 32'h0;
    for (int i = 0; i < 11; i++) begin
      if (!vt[i].b2b) idle_gap($sformatf("vec%0d", i), 2, prev_res);
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].cyc,
             vt[i].res, vt[i].flags, vt[i].comp, vt[i].spur);
      prev_res = vt[i].res;
    end
    // odone must be a single pulse after the last op
    idle_gap("after_vec", 3, prev_res);

    // Reset three cycles into an ADD: everything clears at once, no odone.
    istart = 1'b1; icontrol = FOPADD; idataa = 32'h40400000; idatab = 32'h40400000;
    tick(); istart = 1'b0;
    tick(); tick();
    chk("pre-reset busy", 32'(obusy), 32'd1);
    ireset = 1'b1;
    #1;
    chk("midreset obusy", 32'(obusy), 32'd0);
    chk("midreset odone", 32'(odone), 32'd0);
    chk("midreset oresult", oresult, 32'd0);
    chk("midreset oflags", 32'(oflags), 32'd0);
    chk("midreset oalu_control", 32'(oalu_control), 32'd0);
    chk("midreset oalu_dataa", oalu_dataa, 32'd0);
    tick();
    ireset = 1'b0;
    nz = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (odone || obusy) nz++;
    end
    chk("aborted op no odone", 32'(nz), 32'd0);
    run_op("after_reset", FOPADD, 32'h3F800000, 32'h40000000, 9, 32'h40400000, 4'b0000, 1'b0, 1'b0);
    prev_res = 32'h40400000;

    // Randomised transactions against the reference model.
    for (int t = 0; t < 40; t++) begin
      op = 5'($urandom_range(0, 31));
      a  = rand_norm();
      b  = rand_norm();
      if (op == FOPCVTSW) a = $urandom;
      e = alu_eval(op, a, b);
      run_op($sformatf("rnd%0d", t), op, a, b, lat_of(op) + 2, e.res, e.flags, e.comp,
             ($urandom_range(0, 3) == 0));
      prev_res = e.res;
      if ($urandom_range(0, 1) == 1) idle_gap($sformatf("rnd%0d", t), $urandom_range(1, 3), prev_res);
    end
    idle_gap("final", 2, prev_res);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
